// File: rtl/fb_kick_driver.sv
// Kicker DAC driver: averages a two-sample feedback window, applies a shift gain,
// saturates, and holds an offset-binary kick for HOLD_CYC cycles before returning to mid-scale.
module fb_kick_driver #(
  parameter int unsigned DAC_W    = 14,
  parameter int unsigned HOLD_CYC = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed [12:0] pout,
  input  logic               fb_cond,
  input  logic               store_strb,
  input  logic               fb_en,
  input  logic [1:0]         gain_shift,
  output logic [DAC_W-1:0]   dac_out,
  output logic               dac_valid,
  output logic               sat_flag,
  output logic [7:0]         fire_count
);

  localparam int unsigned CALC_W = 17;
  localparam int unsigned CNT_W  = 8;

  localparam logic [DAC_W-1:0]         DAC_MID  = {1'b1, {(DAC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]         HOLD_LD  = CNT_W'(HOLD_CYC);
  localparam logic [CNT_W-1:0]         CNT_MAX  = {CNT_W{1'b1}};
  localparam logic signed [CALC_W-1:0] KICK_MAX = CALC_W'((2 ** (DAC_W - 1)) - 1);
  localparam logic signed [CALC_W-1:0] KICK_MIN = -KICK_MAX - CALC_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_FIRST,
    S_CALC,
    S_DRIVE
  } state_t;

  state_t                    r_state;
  logic signed [12:0]        r_s0;
  logic signed [12:0]        r_s1;
  logic [CNT_W-1:0]          r_hold;

  logic signed [13:0]        w_sum;
  logic signed [CALC_W-1:0]  w_shl;
  logic signed [CALC_W-1:0]  w_scaled;
  logic signed [CALC_W-1:0]  w_clamp;
  logic                      w_sat;
  logic [DAC_W-1:0]          w_kick;
  logic [DAC_W-1:0]          w_dac;
  logic                      w_abort;
  logic                      w_unused_bits;

  // Kick datapath: floor-average with gain, clamp to DAC range, flip MSB for offset binary
  always_comb begin
    w_sum    = {r_s0[12], r_s0} + {r_s1[12], r_s1};
    w_shl    = CALC_W'(w_sum) <<< gain_shift;
    w_scaled = w_shl >>> 1;
    w_clamp  = w_scaled;
    w_sat    = 1'b0;
    if (w_scaled > KICK_MAX) begin
      w_clamp = KICK_MAX;
      w_sat   = 1'b1;
    end else if (w_scaled < KICK_MIN) begin
      w_clamp = KICK_MIN;
      w_sat   = 1'b1;
    end
    w_kick        = w_clamp[DAC_W-1:0];
    w_dac         = {~w_kick[DAC_W-1], w_kick[DAC_W-2:0]};
    w_unused_bits = ^w_clamp[CALC_W-1:DAC_W];
  end

  assign w_abort = ~store_strb | ~fb_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_s0       <= '0;
      r_s1       <= '0;
      r_hold     <= '0;
      dac_out    <= DAC_MID;
      dac_valid  <= 1'b0;
      sat_flag   <= 1'b0;
      fire_count <= '0;
    end else if (w_abort) begin
      r_state   <= S_IDLE;
      dac_out   <= DAC_MID;
      dac_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state    <= S_ARMED;
          fire_count <= '0;
          sat_flag   <= 1'b0;
        end
        S_ARMED: begin
          if (fb_cond) begin
            r_s0    <= pout;
            r_state <= S_FIRST;
          end
        end
        S_FIRST: begin
          // A single-cycle window duplicates the first sample
          r_s1    <= fb_cond ? pout : r_s0;
          r_state <= S_CALC;
        end
        S_CALC: begin
          dac_out   <= w_dac;
          dac_valid <= 1'b1;
          r_hold    <= HOLD_LD;
          if (w_sat) sat_flag <= 1'b1;
          if (fire_count != CNT_MAX) fire_count <= fire_count + CNT_W'(1);
          r_state   <= S_DRIVE;
        end
        S_DRIVE: begin
          if (r_hold <= CNT_W'(1)) begin
            dac_out   <= DAC_MID;
            dac_valid <= 1'b0;
            r_state   <= S_ARMED;
          end else begin
            r_hold <= r_hold - CNT_W'(1);
          end
        end
        default: begin
          r_state   <= S_IDLE;
          dac_out   <= DAC_MID;
          dac_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
